if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with optional direct-mapped I-cache and flush handling
//
// Optional feature: define ICACHE_EN to build the direct-mapped instruction cache.
// Without it there is no cache storage, every fetch goes to memory and fills are no-ops.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset (priority over rdy and jump_or_not)
//   rdy          global ready; low freezes state, outputs and cache
//   pc_i         fetch address from the PC register
//   jump_or_not  flush: a redirect is taken this cycle
//   if_stall     downstream IF/ID register cannot accept
//   pc_reg_stall hold the PC register (combinational)
//   mem_req      memory fetch request, held until mem_done
//   mem_addr     fetch address presented to memory
//   mem_done     one-cycle pulse: mem_inst is valid
//   mem_inst     instruction word returned by memory
//   if_valid     if_pc/if_inst carry a live instruction
//   if_pc        PC of the fetched instruction
//   if_inst      fetched instruction word
module if_stage #(
    parameter int ICACHE_IDX = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] pc_i,
    input  logic        jump_or_not,
    input  logic        if_stall,
    output logic        pc_reg_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_inst,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;

    logic        hit;
    logic [31:0] hit_data;
    logic        hold;

    assign hold = if_valid_q && if_stall;

`ifdef ICACHE_EN
    localparam int LINES = 1 << ICACHE_IDX;
    localparam int TAG_W = 30 - ICACHE_IDX;

    logic [LINES-1:0]      cv_q;
    logic [TAG_W-1:0]      ctag_q  [LINES];
    logic [31:0]           cdata_q [LINES];
    logic [ICACHE_IDX-1:0] rd_idx, wr_idx;
    logic                  fill;

    assign rd_idx   = pc_i[ICACHE_IDX+1:2];
    assign wr_idx   = mem_addr_q[ICACHE_IDX+1:2];
    assign hit      = cv_q[rd_idx] && (ctag_q[rd_idx] == pc_i[31:ICACHE_IDX+2]);
    assign hit_data = cdata_q[rd_idx];
    // Every returning fetch fills, including ones whose result is dropped by a flush.
    assign fill     = rdy && (state_q != IDLE) && mem_done;

    always_ff @(posedge clk) begin
        if (!rst)
            cv_q <= '0;
        else if (fill)
            cv_q[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst && fill) begin
            ctag_q[wr_idx]  <= mem_addr_q[31:ICACHE_IDX+2];
            cdata_q[wr_idx] <= mem_inst;
        end
    end
`else
    logic unused_idx;

    assign unused_idx = (ICACHE_IDX > 0);
    assign hit        = 1'b0;
    assign hit_data   = '0;
`endif

    // State register; rdy low freezes everything, reset overrides rdy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = (!jump_or_not && !hold && !hit) ? WAIT : IDLE;
            WAIT:    state_d = mem_done ? IDLE : (jump_or_not ? DISCARD : WAIT);
            DISCARD: state_d = mem_done ? IDLE : DISCARD;
            default: state_d = IDLE;
        endcase
    end

    // Output next-values; anything not assigned holds.
    always_comb begin
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        unique case (state_q)
            IDLE: begin
                if (jump_or_not) begin
                    if_valid_d = 1'b0;
                end else if (!hold) begin
                    if (hit) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_i;
                        if_inst_d  = hit_data;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_i;
                        if_valid_d = 1'b0;
                    end
                end
            end
            WAIT: begin
                if (mem_done) begin
                    mem_req_d  = 1'b0;
                    // A flush arriving with the data still drops the result.
                    if_valid_d = !jump_or_not;
                    if (!jump_or_not) begin
                        if_pc_d   = mem_addr_q;
                        if_inst_d = mem_inst;
                    end
                end else if (jump_or_not) begin
                    if_valid_d = 1'b0;
                end
            end
            DISCARD: begin
                if (mem_done)
                    mem_req_d = 1'b0;
            end
            default: begin
                mem_req_d  = 1'b0;
                if_valid_d = 1'b0;
            end
        endcase
    end

    // The PC must hold while a fetch is outstanding, while downstream holds a
    // live instruction, or when the current PC will miss and start a fetch.
    assign pc_reg_stall = (state_q != IDLE) || hold || !hit;

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;

endmodule
